// File: rtl/key_loader_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : key_loader_if
// Brief    : Load request plus bit-serial valid/ready key channel.
// Revision : 1.0
//------------------------------------------------------------------------------
interface key_loader_if;
  logic load_start;
  logic ser_valid;
  logic ser_data;
  logic ser_ready;

  modport master (
    output load_start,
    output ser_valid,
    output ser_data,
    input  ser_ready
  );

  modport slave (
    input  load_start,
    input  ser_valid,
    input  ser_data,
    output ser_ready
  );
endinterface
`default_nettype wire

// File: rtl/key_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : key_loader
// Brief    : Serial key loader with even-parity check and fail lockout.
// Revision : 1.0
//------------------------------------------------------------------------------
module key_loader #(
  parameter int KEY_W    = 4,
  parameter int MAX_FAIL = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  key_loader_if.slave           ser,
  output logic [KEY_W-1:0]      key_out,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  err,
  output logic                  locked_out
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(KEY_W);
  localparam logic [2:0]       c_max_fail = 3'(MAX_FAIL);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CHECK   = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [KEY_W-1:0] r_shadow;
  logic             r_parity;
  logic [2:0]       r_fail_cnt;
  logic [KEY_W-1:0] r_key_out;
  logic             r_key_valid;
  logic             r_err;
  logic             r_locked_out;

  logic             w_parity_ok;
  logic [2:0]       w_fail_next;

  assign w_parity_ok = ~(^r_shadow ^ r_parity);
  assign w_fail_next = (r_fail_cnt >= c_max_fail) ? r_fail_cnt : r_fail_cnt + 3'd1;

  assign ser.ser_ready = (r_state == S_SHIFT);
  assign busy          = (r_state == S_SHIFT) || (r_state == S_CHECK);
  assign key_out       = r_key_out;
  assign key_valid     = r_key_valid;
  assign err           = r_err;
  assign locked_out    = r_locked_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shadow     <= '0;
      r_parity     <= 1'b0;
      r_fail_cnt   <= 3'd0;
      r_key_out    <= '0;
      r_key_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ser.load_start) begin
            r_bit_cnt <= '0;
            r_shadow  <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // ser_ready is 1 throughout SHIFT, so ser_valid alone marks a transfer
          if (ser.ser_valid) begin
            if (r_bit_cnt == c_bit_last) begin
              r_parity <= ser.ser_data;
              r_state  <= S_CHECK;
            end else begin
              r_shadow  <= {r_shadow[KEY_W-2:0], ser.ser_data};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (w_parity_ok) begin
            r_key_out   <= r_shadow;
            r_key_valid <= 1'b1;
            r_fail_cnt  <= 3'd0;
            r_state     <= S_IDLE;
          end else begin
            r_err      <= 1'b1;
            r_fail_cnt <= w_fail_next;
            if (w_fail_next == c_max_fail) begin
              r_key_out    <= '0;
              r_key_valid  <= 1'b0;
              r_locked_out <= 1'b1;
              r_state      <= S_LOCKOUT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_LOCKOUT: begin
          r_key_out    <= '0;
          r_key_valid  <= 1'b0;
          r_locked_out <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_key_loader
// Brief    : Directed self-checking bench for key_loader.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_key_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_out;
  logic       key_valid, busy, err, locked_out;
  int         total = 0;
  int         bad = 0;

  key_loader_if kif ();

  key_loader #(.KEY_W(4), .MAX_FAIL(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser        (kif.slave),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    kif.load_start = 1'b1;
    step();
    kif.load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    kif.ser_valid = 1'b1;
    kif.ser_data  = b;
    step();
    kif.ser_valid = 1'b0;
  endtask

  // Full load; returns one cycle after the CHECK edge with results visible.
  task automatic load(input logic [3:0] k, input logic p, input logic [3:0] key_before);
    start_load();
    chk1("shift_ready", kif.ser_ready, 1'b1);
    chk1("shift_busy", busy, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      send_bit(k[i]);
      chk4("shift_key_hold", key_out, key_before);
    end
    send_bit(p);
    chk1("check_busy", busy, 1'b1);
    chk1("check_ready", kif.ser_ready, 1'b0);
    chk1("check_err_lat", err, 1'b0);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    kif.load_start = 1'b0;
    kif.ser_valid  = 1'b0;
    kif.ser_data   = 1'b0;

    // Reset values
    #12;
    chk4("rst_key", key_out, 4'b0000);
    chk1("rst_kv", key_valid, 1'b0);
    chk1("rst_ready", kif.ser_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_lock", locked_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk1("idle_ready", kif.ser_ready, 1'b0);

    // Clean load 1011, parity 1
    load(4'b1011, 1'b1, 4'b0000);
    chk4("clean_key", key_out, 4'b1011);
    chk1("clean_kv", key_valid, 1'b1);
    chk1("clean_err", err, 1'b0);
    chk1("clean_idle", busy, 1'b0);

    // Stall: 5 idle cycles between bits 2 and 3
    do_reset();
    start_load();
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("stall_ready", kif.ser_ready, 1'b1);
      chk4("stall_key", key_out, 4'b0000);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    chk1("stall_not_done", busy, 1'b1);
    chk1("stall_still_shift", kif.ser_ready, 1'b1);
    send_bit(1'b1);
    step();
    chk4("stall_key_final", key_out, 4'b1011);
    chk1("stall_kv", key_valid, 1'b1);

    // Single failure: 0110 parity 1
    load(4'b0110, 1'b1, 4'b1011);
    chk1("fail1_err", err, 1'b1);
    chk4("fail1_key", key_out, 4'b1011);
    chk1("fail1_kv", key_valid, 1'b1);
    chk1("fail1_lock", locked_out, 1'b0);
    step();
    chk1("fail1_err_pulse", err, 1'b0);
    chk1("fail1_idle", busy, 1'b0);

    // Second bad, then good clears the counter
    load(4'b0110, 1'b1, 4'b1011);
    chk1("fail2_err", err, 1'b1);
    chk1("fail2_lock", locked_out, 1'b0);
    load(4'b0110, 1'b0, 4'b1011);
    chk4("good_key", key_out, 4'b0110);
    chk1("good_err", err, 1'b0);
    // Bad, bad after clear: counter reaches 2, no lockout yet
    load(4'b0110, 1'b1, 4'b0110);
    chk1("clr_fail1_lock", locked_out, 1'b0);
    load(4'b0110, 1'b1, 4'b0110);
    chk1("clr_fail2_err", err, 1'b1);
    chk1("clr_fail2_lock", locked_out, 1'b0);
    chk4("clr_fail2_key", key_out, 4'b0110);

    // Third consecutive bad load trips lockout
    load(4'b0110, 1'b1, 4'b0110);
    chk1("lock_err", err, 1'b1);
    chk1("lock_flag", locked_out, 1'b1);
    chk4("lock_key", key_out, 4'b0000);
    chk1("lock_kv", key_valid, 1'b0);
    start_load();
    for (int i = 0; i < 3; i++) begin
      chk1("lock_ready", kif.ser_ready, 1'b0);
      chk1("lock_busy", busy, 1'b0);
      step();
    end
    chk1("lock_err_clear", err, 1'b0);
    chk1("lock_hold", locked_out, 1'b1);
    do_reset();
    chk1("lock_rst_clear", locked_out, 1'b0);

    // Async reset mid-shift
    load(4'b1011, 1'b1, 4'b0000);
    chk1("pre_async_kv", key_valid, 1'b1);
    start_load();
    send_bit(1'b0);
    send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_key", key_out, 4'b0000);
    chk1("async_kv", key_valid, 1'b0);
    chk1("async_ready", kif.ser_ready, 1'b0);
    chk1("async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    load(4'b1111, 1'b0, 4'b0000);
    chk4("fresh_key", key_out, 4'b1111);
    chk1("fresh_kv", key_valid, 1'b1);
    chk1("fresh_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
